// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and load/store
// accesses onto a single 8-bit RAM port, one byte address per cycle.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ifReq_in,
    input  logic [31:0] ifAddr_in,
    output logic        ifDone_out,
    output logic [31:0] ifInst_out,
    input  logic        memReq_in,
    input  logic        memWe_in,
    input  logic [31:0] memAddr_in,
    input  logic [1:0]  memLen_in,
    input  logic [31:0] memData_in,
    output logic        memDone_out,
    output logic [31:0] memData_out,
    output logic        stall_out,
    output logic [31:0] ramAddr_out,
    output logic        ramWe_out,
    output logic [7:0]  ramData_out,
    input  logic [7:0]  ramData_in
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IF_RD  = 2'd1;
    localparam logic [1:0] MEM_RD = 2'd2;
    localparam logic [1:0] MEM_WR = 2'd3;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic [2:0]  len_q;
    logic [2:0]  cnt_q;
    logic [2:0]  mem_len;
    logic [31:0] next_addr;
    logic [31:0] rd_word;
    logic [7:0]  wr_byte;

    assign stall_out = memReq_in & ~memDone_out;

    always_comb begin
        case (memLen_in)
            2'b00:   mem_len = 3'd1;
            2'b01:   mem_len = 3'd2;
            default: mem_len = 3'd4;
        endcase
    end

    // cnt_q holds k while in address/data cycle ck
    assign next_addr = addr_q + {29'd0, cnt_q};

    // The byte on ramData_in in cycle ck belongs to result byte k-2
    always_comb begin
        rd_word = rbuf_q;
        case (cnt_q)
            3'd2:    rd_word[7:0]   = ramData_in;
            3'd3:    rd_word[15:8]  = ramData_in;
            3'd4:    rd_word[23:16] = ramData_in;
            3'd5:    rd_word[31:24] = ramData_in;
            default: ;
        endcase
    end

    always_comb begin
        case (cnt_q[1:0])
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            2'd3:    wr_byte = wdata_q[31:24];
            default: wr_byte = wdata_q[7:0];
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rbuf_q      <= 32'd0;
            len_q       <= 3'd0;
            cnt_q       <= 3'd0;
            ifDone_out  <= 1'b0;
            ifInst_out  <= 32'd0;
            memDone_out <= 1'b0;
            memData_out <= 32'd0;
            ramAddr_out <= 32'd0;
            ramWe_out   <= 1'b0;
            ramData_out <= 8'd0;
        end else begin
            ifDone_out  <= 1'b0;
            memDone_out <= 1'b0;
            case (state)
                IDLE: begin
                    // A requester whose done pulse is showing is not re-accepted
                    if (memReq_in && !memDone_out) begin
                        addr_q      <= memAddr_in;
                        wdata_q     <= memData_in;
                        len_q       <= mem_len;
                        rbuf_q      <= 32'd0;
                        cnt_q       <= 3'd1;
                        ramAddr_out <= memAddr_in;
                        if (memWe_in) begin
                            state       <= MEM_WR;
                            ramWe_out   <= 1'b1;
                            ramData_out <= memData_in[7:0];
                        end else begin
                            state <= MEM_RD;
                        end
                    end else if (ifReq_in && !ifDone_out) begin
                        addr_q      <= ifAddr_in;
                        len_q       <= 3'd4;
                        rbuf_q      <= 32'd0;
                        cnt_q       <= 3'd1;
                        ramAddr_out <= ifAddr_in;
                        state       <= IF_RD;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state == IF_RD && !ifReq_in) begin
                        state       <= IDLE;
                        cnt_q       <= 3'd0;
                        ramAddr_out <= 32'd0;
                    end else begin
                        if (cnt_q >= 3'd2)
                            rbuf_q <= rd_word;
                        if (cnt_q < len_q)
                            ramAddr_out <= next_addr;
                        else
                            ramAddr_out <= 32'd0;
                        if (cnt_q == len_q + 3'd1) begin
                            state <= IDLE;
                            cnt_q <= 3'd0;
                            if (state == IF_RD) begin
                                ifDone_out <= 1'b1;
                                ifInst_out <= rd_word;
                            end else begin
                                memDone_out <= 1'b1;
                                memData_out <= rd_word;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                MEM_WR: begin
                    if (cnt_q < len_q) begin
                        ramAddr_out <= next_addr;
                        ramWe_out   <= 1'b1;
                        ramData_out <= wr_byte;
                        cnt_q       <= cnt_q + 3'd1;
                    end else begin
                        ramAddr_out <= 32'd0;
                        ramWe_out   <= 1'b0;
                        ramData_out <= 8'd0;
                        memDone_out <= 1'b1;
                        cnt_q       <= 3'd0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
